// File: rtl/pic_host_sequencer_pkg.sv
// Shared types, ICW1 bit positions and timer width for the PIC host sequencer.
package pic_host_sequencer_pkg;

  localparam int CNT_W     = 4;
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_MARK = 4;

  typedef enum logic [3:0] {
    ST_UNINIT,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP,
    ST_IDLE,
    ST_INTA1,
    ST_INTA_GAP,
    ST_INTA2
  } state_t;

  typedef enum logic [1:0] {
    ICW_1,
    ICW_2,
    ICW_3,
    ICW_4
  } icw_t;

  typedef struct packed {
    logic more;
    icw_t idx;
  } icw_step_t;

  // ICW3 only exists in cascade mode, ICW4 only when ICW1 asks for it.
  function automatic icw_step_t next_icw(input icw_t cur, input logic sngl, input logic ic4);
    icw_step_t s;
    s.more = 1'b0;
    s.idx  = ICW_1;
    case (cur)
      ICW_1: begin
        s.more = 1'b1;
        s.idx  = ICW_2;
      end
      ICW_2: begin
        if (!sngl) begin
          s.more = 1'b1;
          s.idx  = ICW_3;
        end else if (ic4) begin
          s.more = 1'b1;
          s.idx  = ICW_4;
        end
      end
      ICW_3: begin
        if (ic4) begin
          s.more = 1'b1;
          s.idx  = ICW_4;
        end
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pic_host_sequencer_if.sv
// Host-side and PIC control signals of the sequencer; the shared DATA bus is a separate inout.
interface pic_host_sequencer_if;

  logic       start;
  logic [7:0] icw1_cfg;
  logic [7:0] icw2_cfg;
  logic [7:0] icw3_cfg;
  logic [7:0] icw4_cfg;
  logic       cmd_valid;
  logic       cmd_rd;
  logic       cmd_a0;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       irq;
  logic       vec_valid;
  logic [7:0] vector;
  logic       wr_enable;
  logic       rd_enable;
  logic       a0;
  logic       inta_n;
  logic       data_oe;
  logic       init_done;

  modport master (
    output start, icw1_cfg, icw2_cfg, icw3_cfg, icw4_cfg,
    output cmd_valid, cmd_rd, cmd_a0, cmd_data, irq,
    input  cmd_ready, rd_valid, rd_data, vec_valid, vector,
    input  wr_enable, rd_enable, a0, inta_n, data_oe, init_done
  );

  modport slave (
    input  start, icw1_cfg, icw2_cfg, icw3_cfg, icw4_cfg,
    input  cmd_valid, cmd_rd, cmd_a0, cmd_data, irq,
    output cmd_ready, rd_valid, rd_data, vec_valid, vector,
    output wr_enable, rd_enable, a0, inta_n, data_oe, init_done
  );

endinterface

// File: rtl/pic_host_sequencer_strobe_timer.sv
// Down-counter timing strobes and gaps; done while the count sits at zero.
module pic_strobe_timer
  import pic_host_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/pic_host_sequencer.sv
// 8259-style PIC host sequencer: ICW programming, host read/write commands and INTA cycles.
// Optional macro PIC_HOST_INT_SYNC_EN adds a two-flop synchronizer on the INT input.
//
// state       | meaning
// UNINIT      | waiting for START
// SETUP       | A0/DATA set up, strobe inactive
// STROBE      | WR_ENABLE or RD_ENABLE active for PULSE_W cycles
// HOLD        | strobe released, write data held, read result presented
// GAP         | bus idle for GAP_W cycles, DATA released
// IDLE        | initialised, serving INT or host commands
// INTA1       | first INTA_ pulse
// INTA_GAP    | INTA_ high between the pulses
// INTA2       | second INTA_ pulse, vector sampled on its last cycle
module pic_host_sequencer
  import pic_host_sequencer_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pic_host_sequencer_if.slave bus,
  inout  wire  [7:0]          io_data
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

  state_t           r_state;
  icw_t             r_icw;
  logic             r_sngl;
  logic             r_ic4;
  logic             r_is_rd;
  logic             r_a0;
  logic [7:0]       r_dout;
  logic             r_data_oe;
  logic             r_wr_en;
  logic             r_rd_en;
  logic             r_inta_n;
  logic             r_rd_valid;
  logic [7:0]       r_rd_data;
  logic             r_vec_valid;
  logic [7:0]       r_vector;
  logic             r_init_done;

  logic             w_irq;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_done;
  icw_step_t        w_step;
  logic [7:0]       w_icw_img;
  logic [7:0]       w_icw1_img;

`ifdef PIC_HOST_INT_SYNC_EN
  logic r_irq_meta;
  logic r_irq_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_meta <= 1'b0;
      r_irq_sync <= 1'b0;
    end else begin
      r_irq_meta <= bus.irq;
      r_irq_sync <= r_irq_meta;
    end
  end

  assign w_irq = r_irq_sync;
`else
  assign w_irq = bus.irq;
`endif

  // Timer is loaded on the edge that enters each timed state.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = PULSE_LD;
    case (r_state)
      ST_SETUP:    w_tmr_load = 1'b1;
      ST_IDLE:     w_tmr_load = w_irq;
      ST_INTA_GAP: w_tmr_load = w_tmr_done;
      ST_HOLD: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = GAP_LD;
      end
      ST_INTA1, ST_INTA2: begin
        w_tmr_load = w_tmr_done;
        w_tmr_val  = GAP_LD;
      end
      default: ;
    endcase
  end

  pic_strobe_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  assign w_step     = next_icw(r_icw, r_sngl, r_ic4);
  assign w_icw1_img = bus.icw1_cfg | (8'h01 << ICW1_MARK);

  always_comb begin
    case (w_step.idx)
      ICW_3:   w_icw_img = bus.icw3_cfg;
      ICW_4:   w_icw_img = bus.icw4_cfg;
      default: w_icw_img = bus.icw2_cfg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_UNINIT;
      r_icw       <= ICW_1;
      r_sngl      <= 1'b0;
      r_ic4       <= 1'b0;
      r_is_rd     <= 1'b0;
      r_a0        <= 1'b0;
      r_dout      <= 8'h00;
      r_data_oe   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_inta_n    <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= 8'h00;
      r_vec_valid <= 1'b0;
      r_vector    <= 8'h00;
      r_init_done <= 1'b0;
    end else begin
      r_rd_valid  <= 1'b0;
      r_vec_valid <= 1'b0;
      case (r_state)
        ST_UNINIT: begin
          if (bus.start) begin
            r_state   <= ST_SETUP;
            r_icw     <= ICW_1;
            r_sngl    <= bus.icw1_cfg[ICW1_SNGL];
            r_ic4     <= bus.icw1_cfg[ICW1_IC4];
            r_is_rd   <= 1'b0;
            r_a0      <= 1'b0;
            r_dout    <= w_icw1_img;
            r_data_oe <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_state <= ST_STROBE;
          r_wr_en <= !r_is_rd;
          r_rd_en <= r_is_rd;
        end
        ST_STROBE: begin
          if (w_tmr_done) begin
            r_state <= ST_HOLD;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            if (r_is_rd) begin
              r_rd_data  <= io_data;
              r_rd_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          r_state   <= ST_GAP;
          r_data_oe <= 1'b0;
        end
        ST_GAP: begin
          if (w_tmr_done) begin
            if (r_init_done) begin
              r_state <= ST_IDLE;
            end else if (w_step.more) begin
              r_state   <= ST_SETUP;
              r_icw     <= w_step.idx;
              r_a0      <= 1'b1;
              r_dout    <= w_icw_img;
              r_data_oe <= 1'b1;
            end else begin
              r_state     <= ST_IDLE;
              r_init_done <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          // A pending interrupt wins; the host command stays stalled on cmd_ready.
          if (w_irq) begin
            r_state  <= ST_INTA1;
            r_inta_n <= 1'b0;
          end else if (bus.cmd_valid) begin
            r_state   <= ST_SETUP;
            r_is_rd   <= bus.cmd_rd;
            r_a0      <= bus.cmd_a0;
            r_dout    <= bus.cmd_data;
            r_data_oe <= !bus.cmd_rd;
          end
        end
        ST_INTA1: begin
          if (w_tmr_done) begin
            r_state  <= ST_INTA_GAP;
            r_inta_n <= 1'b1;
          end
        end
        ST_INTA_GAP: begin
          if (w_tmr_done) begin
            r_state  <= ST_INTA2;
            r_inta_n <= 1'b0;
          end
        end
        ST_INTA2: begin
          if (w_tmr_done) begin
            r_state     <= ST_GAP;
            r_inta_n    <= 1'b1;
            r_vector    <= io_data;
            r_vec_valid <= 1'b1;
          end
        end
        default: r_state <= ST_UNINIT;
      endcase
    end
  end

  assign io_data       = r_data_oe ? r_dout : 8'bz;
  assign bus.cmd_ready = (r_state == ST_IDLE) && r_init_done && !w_irq;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.vec_valid = r_vec_valid;
  assign bus.vector    = r_vector;
  assign bus.wr_enable = r_wr_en;
  assign bus.rd_enable = r_rd_en;
  assign bus.a0        = r_a0;
  assign bus.inta_n    = r_inta_n;
  assign bus.data_oe   = r_data_oe;
  assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Scoreboard bench for pic_host_sequencer: ICW sequences, host commands, INTA cycles, reset.
module tb_pic_host_sequencer;

  localparam int PULSE_W = 2;
  localparam int GAP_W   = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] pic_val = 8'h00;
  wire  [7:0] io_data;

  pic_host_sequencer_if bus ();

  pic_host_sequencer #(.PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .io_data (io_data)
  );

  // PIC model: drives DATA while a read strobe or INTA_ is active.
  assign io_data = (bus.rd_enable || !bus.inta_n) ? pic_val : 8'bz;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, vec_cnt = 0, inta_pulses = 0;
  int wr_cyc = 0, vec_cyc = 0, wr_fall_cyc = 0, excl_viol = 0;

  logic [8:0] exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_vec[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus monitor: pops the scoreboard on every strobe, result and vector.
  initial begin
    logic       prev_wr, prev_rd, prev_inta, prev_oe, gap_pend;
    logic [7:0] prev_data;
    logic [8:0] cur_w;
    logic [7:0] e8;
    int         wr_w, lo_w, hi_w;
    prev_wr = 0; prev_rd = 0; prev_inta = 1; prev_oe = 0; gap_pend = 0;
    prev_data = 0; cur_w = 0; e8 = 0; wr_w = 0; lo_w = 0; hi_w = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wr = 0; prev_rd = 0; prev_inta = 1; gap_pend = 0;
      end else begin
        if ((int'(bus.wr_enable) + int'(bus.rd_enable) + int'(!bus.inta_n)) > 1) excl_viol++;
        if (gap_pend) begin
          chk("wr_gap_release", bus.data_oe, 1'b0);
          gap_pend = 0;
        end
        if (bus.wr_enable && !prev_wr) begin
          chk("wr_queued", exp_wr.size() > 0, 1'b1);
          if (exp_wr.size() > 0) begin
            cur_w = exp_wr.pop_front();
            chk("wr_a0", bus.a0, cur_w[8]);
            chk("wr_data", io_data, cur_w[7:0]);
            chk("wr_setup", {prev_oe, prev_data}, {1'b1, cur_w[7:0]});
          end
          wr_w = 1;
          wr_cnt++;
          wr_cyc = cyc;
        end else if (bus.wr_enable) begin
          wr_w++;
        end else if (prev_wr) begin
          chk("wr_width", wr_w, PULSE_W);
          chk("wr_hold", {bus.data_oe, io_data}, {1'b1, cur_w[7:0]});
          gap_pend = 1;
          wr_fall_cyc = cyc;
        end
        if (!bus.inta_n) begin
          if (prev_inta) begin
            inta_pulses++;
            if (inta_pulses % 2 == 0) chk("inta_gap", hi_w, GAP_W);
            lo_w = 1;
          end else begin
            lo_w++;
          end
        end else begin
          if (!prev_inta) begin
            chk("inta_width", lo_w, PULSE_W);
            hi_w = 1;
          end else begin
            hi_w++;
          end
        end
        if (bus.rd_valid) begin
          chk("rd_queued", exp_rd.size() > 0, 1'b1);
          if (exp_rd.size() > 0) begin
            e8 = exp_rd.pop_front();
            chk("rd_data", bus.rd_data, e8);
          end
          chk("rd_on_hold", {bus.rd_enable, prev_rd}, 2'b01);
          rd_cnt++;
        end
        if (bus.vec_valid) begin
          chk("vec_queued", exp_vec.size() > 0, 1'b1);
          if (exp_vec.size() > 0) begin
            e8 = exp_vec.pop_front();
            chk("vector", bus.vector, e8);
          end
          chk("vec_after_inta2", {bus.inta_n, prev_inta}, 2'b10);
          vec_cnt++;
          vec_cyc = cyc;
        end
        prev_wr = bus.wr_enable; prev_rd = bus.rd_enable; prev_inta = bus.inta_n;
        prev_oe = bus.data_oe;   prev_data = io_data;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!bus.init_done && n < 400) begin @(negedge clk); n++; end
    chk("init_done", bus.init_done, 1'b1);
    chk("init_all_written", exp_wr.size(), 0);
    chk("init_latency", cyc - wr_fall_cyc, GAP_W + 1);
  endtask

  // Called at a negedge; holds cmd_valid until the handshake completes.
  task automatic send_cmd(input logic rd, input logic a0, input logic [7:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_rd = rd; bus.cmd_a0 = a0; bus.cmd_data = d;
    #1;
    while (!bus.cmd_ready && n < 300) begin @(negedge clk); #1; n++; end
    chk("cmd_accept", bus.cmd_ready, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    #1;
    while (!bus.cmd_ready && n < 300) begin @(negedge clk); #1; n++; end
    chk("back_to_idle", bus.cmd_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_inta(input logic lvl);
    int n = 0;
    while (bus.inta_n !== lvl && n < 300) begin @(negedge clk); n++; end
    chk("inta_wait", bus.inta_n, lvl);
  endtask

  initial begin
    int n;
    bus.start = 0; bus.cmd_valid = 0; bus.cmd_rd = 0; bus.cmd_a0 = 0; bus.cmd_data = 0;
    bus.irq = 0;
    bus.icw1_cfg = 8'h13; bus.icw2_cfg = 8'h20; bus.icw3_cfg = 8'h04; bus.icw4_cfg = 8'h01;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", bus.wr_enable, 1'b0);
    chk("rst_rd_en", bus.rd_enable, 1'b0);
    chk("rst_inta_n", bus.inta_n, 1'b1);
    chk("rst_a0", bus.a0, 1'b0);
    chk("rst_data_oe", bus.data_oe, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_valids", {bus.rd_valid, bus.vec_valid}, 2'b00);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_vector", bus.vector, 8'h00);
    chk("rst_init_done", bus.init_done, 1'b0);
    rst_n = 1'b1;

    // INT and commands before initialisation are ignored.
    bus.irq = 1'b1; bus.cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("uninit_not_ready", bus.cmd_ready, 1'b0);
    bus.irq = 1'b0; bus.cmd_valid = 1'b0;

    // ICW1=0x02: single mode, no ICW4 -> two writes; a second START is ignored.
    bus.icw1_cfg = 8'h02;
    exp_wr.push_back({1'b0, 8'h12});
    exp_wr.push_back({1'b1, 8'h20});
    pulse_start();
    n = 0;
    while (wr_cnt == 0 && n < 100) begin @(negedge clk); n++; end
    chk("first_write", wr_cnt > 0, 1'b1);
    pulse_start();
    wait_init();

    // ICW1=0x01: cascade with ICW4 -> four writes.
    do_reset();
    bus.icw1_cfg = 8'h01;
    exp_wr.push_back({1'b0, 8'h11});
    exp_wr.push_back({1'b1, 8'h20});
    exp_wr.push_back({1'b1, 8'h04});
    exp_wr.push_back({1'b1, 8'h01});
    pulse_start();
    wait_init();

    // ICW1=0x13: single with ICW4 -> three writes, no ICW3.
    do_reset();
    bus.icw1_cfg = 8'h13;
    exp_wr.push_back({1'b0, 8'h13});
    exp_wr.push_back({1'b1, 8'h20});
    exp_wr.push_back({1'b1, 8'h01});
    pulse_start();
    wait_init();
    chk("no_inta_before_init", inta_pulses, 0);

    // Host write and two reads.
    @(negedge clk);
    exp_wr.push_back({1'b1, 8'hFB});
    send_cmd(1'b0, 1'b1, 8'hFB);
    wait_ready();
    pic_val = 8'h5A;
    exp_rd.push_back(8'h5A);
    send_cmd(1'b1, 1'b1, 8'h00);
    @(negedge clk);
    chk("rd_a0", {bus.rd_enable, bus.a0}, 2'b11);
    wait_ready();
    pic_val = 8'hC3;
    exp_rd.push_back(8'hC3);
    send_cmd(1'b1, 1'b0, 8'h00);
    wait_ready();
    chk("rd_count", rd_cnt, 2);

    // Interrupt acknowledge; INT drops during INTA1, vector still delivered.
    pic_val = 8'hEE;
    exp_vec.push_back(8'h24);
    bus.irq = 1'b1;
    wait_inta(1'b0);
    bus.irq = 1'b0;
    wait_inta(1'b1);
    pic_val = 8'h24;
    wait_ready();
    chk("vec_count_1", vec_cnt, 1);

    // INT and CMD_VALID together: acknowledge first, command after.
    pic_val = 8'hEE;
    exp_vec.push_back(8'h5C);
    exp_wr.push_back({1'b0, 8'h3C});
    bus.irq = 1'b1;
`ifdef PIC_HOST_INT_SYNC_EN
    repeat (2) @(negedge clk);
`endif
    fork
      send_cmd(1'b0, 1'b0, 8'h3C);
      begin
        wait_inta(1'b0);
        bus.irq = 1'b0;
        wait_inta(1'b1);
        pic_val = 8'h5C;
      end
    join
    wait_ready();
    chk("vec_count_2", vec_cnt, 2);
    chk("ack_before_cmd", vec_cyc < wr_cyc, 1'b1);

    // Reset in the middle of a read strobe.
    pic_val = 8'h77;
    send_cmd(1'b1, 1'b0, 8'h00);
    n = 0;
    while (!bus.rd_enable && n < 50) begin @(negedge clk); n++; end
    chk("rd_strobe_seen", bus.rd_enable, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_en", bus.rd_enable, 1'b0);
    chk("rst_mid_init_done", bus.init_done, 1'b0);
    chk("rst_mid_oe", bus.data_oe, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_reinit_without_start", bus.init_done, 1'b0);
    chk("no_rd_valid_after_rst", rd_cnt, 2);

    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("vec_queue_drained", exp_vec.size(), 0);
    chk("strobe_exclusive", excl_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pic_host_sequencer.md
PIC_HOST_SEQUENCER -- requirements
Module: pic_host_sequencer

Interface
REQ-001 Parameter PULSE_W, default 2, SHALL set the number of CLK cycles each WR_ENABLE, RD_ENABLE or INTA_ strobe is active (legal range 1..15).
REQ-002 Parameter GAP_W, default 2, SHALL set the number of idle CLK cycles after every strobe (legal range 1..15).
REQ-003 Ports: CLK in 1 system clock; RST_ in 1 reset, asynchronous, active-low.
REQ-004 Init inputs: START in 1 pulse to begin programming; ICW1_CFG, ICW2_CFG, ICW3_CFG, ICW4_CFG in 8 each, register images.
REQ-005 Command inputs: CMD_VALID in 1; CMD_RD in 1 (1 read, 0 write); CMD_A0 in 1; CMD_DATA in 8. Output CMD_READY out 1.
REQ-006 Command result outputs: RD_VALID out 1 (one-cycle pulse); RD_DATA out 8.
REQ-007 Interrupt ports: INT in 1 from PIC; VEC_VALID out 1 (one-cycle pulse); VECTOR out 8.
REQ-008 PIC bus: WR_ENABLE out 1 active-high; RD_ENABLE out 1 active-high; A0 out 1; INTA_ out 1 active-low; DATA inout 8.
REQ-009 Status: INIT_DONE out 1, high once the ICW sequence has completed.

Function
REQ-010 FSM states SHALL be: UNINIT, SETUP, STROBE, HOLD, GAP, IDLE, INTA1, INTA_GAP, INTA2; a 4-bit counter SHALL time STROBE, GAP, INTA1, INTA_GAP, INTA2.
REQ-011 In UNINIT, START high SHALL begin writing ICW1 (A0=0); ICW1_CFG bit 4 SHALL be forced to 1 on the bus.
REQ-012 After ICW1: ICW2 (A0=1); then ICW3 (A0=1) only if ICW1_CFG[1]=0; then ICW4 (A0=1) only if ICW1_CFG[0]=1; then IDLE with INIT_DONE=1.
REQ-013 Write cycle: SETUP 1 cycle (A0, DATA driven, WR_ENABLE=0); STROBE PULSE_W cycles (WR_ENABLE=1); HOLD 1 cycle (WR_ENABLE=0, DATA still driven); GAP GAP_W cycles (DATA released to Z).
REQ-014 Read cycle: SETUP 1 cycle (A0 driven, DATA Z); STROBE PULSE_W cycles (RD_ENABLE=1); DATA sampled on the last STROBE cycle; RD_VALID/RD_DATA presented on the HOLD cycle; then GAP.
REQ-015 CMD_READY SHALL be 1 only in IDLE with INIT_DONE=1 and sampled INT low; a command is accepted when CMD_VALID and CMD_READY are both high in one cycle.
REQ-016 In IDLE, sampled INT high SHALL take priority over a simultaneous CMD_VALID; the command SHALL wait, not be dropped.
REQ-017 Acknowledge: INTA1 drives INTA_=0 for PULSE_W cycles; INTA_GAP drives INTA_=1 for GAP_W cycles; INTA2 drives INTA_=0 for PULSE_W cycles; DATA sampled on the last INTA2 cycle; VEC_VALID pulses on the following cycle; then GAP.
REQ-018 INT falling during INTA1/INTA_GAP/INTA2 SHALL NOT abort the sequence; the vector SHALL be delivered regardless.
REQ-019 A bus cycle or acknowledge in progress SHALL always complete; INT is only examined in IDLE.
REQ-020 START while not in UNINIT SHALL be ignored; before INIT_DONE, INT and CMD_VALID SHALL be ignored.
REQ-021 WR_ENABLE, RD_ENABLE and INTA_ low SHALL never be active in the same cycle.

Reset
REQ-022 RST_ low SHALL asynchronously force: state UNINIT, WR_ENABLE=0, RD_ENABLE=0, INTA_=1, A0=0, DATA=Z, CMD_READY=0, RD_VALID=0, VEC_VALID=0, RD_DATA=0, VECTOR=0, INIT_DONE=0, counter 0.
REQ-023 Reset mid-strobe SHALL end the strobe immediately; re-initialisation requires a new START.

Configuration
REQ-024 With PIC_HOST_INT_SYNC_EN defined, INT SHALL pass through a two-flop synchronizer (2 cycles added latency to the INTA1 start); without it, INT SHALL be sampled directly by the FSM.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the ICW1 bit positions (IC4=0, SNGL=1, bit4 marker) and the 4-bit counter width.
REQ-026 Strobe/counter timing SHALL live in one sub-module, pic_strobe_timer (load, count down, done); the synchronizer is inline.

Verification
REQ-027 ICW1=0x13, ICW2=0x20, START -> writes 0x13@A0=0, 0x20@A0=1, 0x??ICW4@A0=1, no ICW3; INIT_DONE after the 3rd GAP.
REQ-028 ICW1=0x01 -> four writes including ICW3; ICW1=0x02 -> two writes only.
REQ-029 After init, CMD write A0=1 data 0xFB -> WR_ENABLE high exactly 2 cycles, DATA=0xFB from SETUP through HOLD, Z in GAP.
REQ-030 INT high, PIC returns 0x24 on DATA during INTA2 -> two INTA_ low pulses of 2 cycles separated by 2 cycles; VEC_VALID with VECTOR=0x24.
REQ-031 INT and CMD_VALID rise in the same IDLE cycle -> acknowledge runs first, then the command completes; no strobe overlap.
REQ-032 RST_ asserted during STROBE of a read -> RD_ENABLE drops in the same cycle, no RD_VALID, INIT_DONE=0.
